// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI burst controller and its RX FIFO.
package spi_pkg;

  typedef logic [7:0] spi_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT_DONE,
    NEXT,
    HOLD
  } burst_state_e;

  localparam int unsigned RX_DEPTH_DEFAULT = 4;
  localparam int unsigned SS_SETUP_DEFAULT = 2;
  localparam int unsigned SS_HOLD_DEFAULT  = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous RX FIFO with first-word-fall-through output; a push into a full
// FIFO is accepted only when the head is popped in the same cycle.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = RX_DEPTH_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  spi_byte_t data_i,
  input  logic      pop_i,
  output spi_byte_t data_o,
  output logic      valid_o,
  output logic      full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  spi_byte_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (count != '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Output is forced to zero while empty so the idle value is deterministic.
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Byte-burst front end for the SPI master core: owns slave select across a burst.
// SPI_BURST_RX_FIFO_EN selects an RX_DEPTH FIFO; otherwise RX is a single holding register.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned RX_DEPTH = RX_DEPTH_DEFAULT,
  parameter int unsigned SS_SETUP = SS_SETUP_DEFAULT,
  parameter int unsigned SS_HOLD  = SS_HOLD_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  spi_byte_t tx_data_i,
  input  logic      tx_valid_i,
  output logic      tx_ready_o,
  input  logic      tx_last_i,
  output spi_byte_t rx_data_o,
  output logic      rx_valid_o,
  input  logic      rx_ready_i,
  output logic      spi_start_o,
  output spi_byte_t spi_din_o,
  input  logic      spi_ready_i,
  input  logic      spi_done_tick_i,
  input  spi_byte_t spi_dout_i,
  output logic      ss_n_o,
  output logic      busy_o,
  output logic      rx_overrun_o
);

  localparam int unsigned CNT_W = $clog2(max_u(SS_SETUP, SS_HOLD) + 1);

  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 || SS_SETUP < 1 || SS_HOLD < 1)
  begin : g_bad_params
    $error("spi_burst_ctrl: invalid RX_DEPTH/SS_SETUP/SS_HOLD");
  end

  burst_state_e     state;
  burst_state_e     state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  spi_byte_t        tx_byte_q;
  logic             last_q;
  logic             tx_accept;
  logic             rx_push;

  assign tx_ready_o = (state == IDLE) || (state == NEXT);
  assign tx_accept  = tx_valid_i && tx_ready_o;
  assign ss_n_o     = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign spi_din_o  = tx_byte_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_byte_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (tx_accept) begin
        tx_byte_q <= tx_data_i;
        last_q    <= tx_last_i;
      end
    end
  end

  // The shared counter times slave-select setup before the first byte and hold after the last.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    spi_start_o = 1'b0;
    rx_push     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_accept) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SS_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) state_d = START;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      START: begin
        if (spi_ready_i) begin
          spi_start_o = 1'b1;
          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (spi_done_tick_i) begin
          rx_push = 1'b1;
          if (last_q) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(SS_HOLD - 1);
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (tx_accept) state_d = START;
      end
      HOLD: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_BURST_RX_FIFO_EN
  logic rx_pop;
  logic rx_full;

  assign rx_pop = rx_valid_o && rx_ready_i;

  spi_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .data_i  (spi_dout_i),
    .pop_i   (rx_pop),
    .data_o  (rx_data_o),
    .valid_o (rx_valid_o),
    .full_o  (rx_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)                                rx_overrun_o <= 1'b0;
    else if (rx_push && rx_full && !rx_pop)   rx_overrun_o <= 1'b1;
  end
`else
  spi_byte_t rx_q;
  logic      rx_vld_q;

  assign rx_data_o  = rx_q;
  assign rx_valid_o = rx_vld_q;

  // A new byte always wins; losing an unread byte is recorded as overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_q         <= '0;
      rx_vld_q     <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else if (rx_push) begin
      rx_q     <= spi_dout_i;
      rx_vld_q <= 1'b1;
      if (rx_vld_q && !rx_ready_i) rx_overrun_o <= 1'b1;
    end else if (rx_ready_i) begin
      rx_vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural SPI core model driven on negedges.
module tb_spi_burst_ctrl;

  localparam int unsigned RX_DEPTH = 4;
  localparam int unsigned SS_SETUP = 2;
  localparam int unsigned SS_HOLD  = 2;
  localparam int          CORE_LAT = 3;
`ifdef SPI_BURST_RX_FIFO_EN
  localparam int FILL = 4;
`else
  localparam int FILL = 1;
`endif

  logic       clk_i           = 1'b0;
  logic       rst_i           = 1'b1;
  logic [7:0] tx_data_i       = 8'h00;
  logic       tx_valid_i      = 1'b0;
  logic       tx_last_i       = 1'b0;
  logic       rx_ready_i      = 1'b0;
  logic       spi_ready_i     = 1'b1;
  logic       spi_done_tick_i = 1'b0;
  logic [7:0] spi_dout_i      = 8'h00;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       spi_start_o;
  logic [7:0] spi_din_o;
  logic       ss_n_o;
  logic       busy_o;
  logic       rx_overrun_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Controls written only by the stimulus process.
  logic [7:0] miso_key   = 8'h00;
  int         rx_mode    = 0;
  int         pop_target = -1;

  // Core model and monitor state, written only by the negedge process.
  logic       start_now;
  logic       pending       = 1'b0;
  int         core_cnt      = 0;
  logic [7:0] core_tx       = 8'h00;
  int         start_count   = 0;
  int         start_cyc     = 0;
  int         done_count    = 0;
  int         done_cyc      = 0;
  int         ss_fall_cyc   = 0;
  int         ss_fall_count = 0;
  int         ss_rise_cyc   = 0;
  int         ss_rise_count = 0;
  int         rx_rise_cyc   = 0;
  int         ovr_rise_done = 0;
  logic       prev_ss       = 1'b1;
  logic       prev_rxv      = 1'b0;
  logic       prev_ovr      = 1'b0;
  logic [7:0] din_log[$];
  logic [7:0] rx_log[$];

  int         t, t2, bs, bl, bd, br, bf;
  logic [7:0] exp_b;

  spi_burst_ctrl #(
    .RX_DEPTH (RX_DEPTH),
    .SS_SETUP (SS_SETUP),
    .SS_HOLD  (SS_HOLD)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .tx_data_i       (tx_data_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .tx_last_i       (tx_last_i),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .spi_start_o     (spi_start_o),
    .spi_din_o       (spi_din_o),
    .spi_ready_i     (spi_ready_i),
    .spi_done_tick_i (spi_done_tick_i),
    .spi_dout_i      (spi_dout_i),
    .ss_n_o          (ss_n_o),
    .busy_o          (busy_o),
    .rx_overrun_o    (rx_overrun_o)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Core model returns din ^ miso_key after CORE_LAT busy cycles; also logs events by cycle.
  always @(negedge clk_i) begin
    start_now = spi_start_o;
    if (prev_ss && !ss_n_o) begin ss_fall_cyc = cyc; ss_fall_count++; end
    if (!prev_ss && ss_n_o) begin ss_rise_cyc = cyc; ss_rise_count++; end
    prev_ss = ss_n_o;
    if (rx_valid_o && !prev_rxv) rx_rise_cyc = cyc;
    prev_rxv = rx_valid_o;
    if (rx_overrun_o && !prev_ovr) ovr_rise_done = done_count;
    prev_ovr = rx_overrun_o;
    spi_done_tick_i = 1'b0;
    if (rst_i) begin
      pending     = 1'b0;
      core_cnt    = 0;
      spi_ready_i = 1'b1;
    end else if (pending) begin
      pending     = 1'b0;
      spi_ready_i = 1'b0;
      core_cnt    = CORE_LAT;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        spi_done_tick_i = 1'b1;
        spi_dout_i      = core_tx ^ miso_key;
        spi_ready_i     = 1'b1;
        done_count++;
        done_cyc = cyc;
      end
    end
    if (start_now && !rst_i) begin
      pending = 1'b1;
      core_tx = spi_din_o;
      start_count++;
      start_cyc = cyc;
      din_log.push_back(spi_din_o);
    end
    rx_ready_i = (rx_mode == 1) ||
                 (rx_mode == 2 && spi_done_tick_i && done_count == pop_target);
    if (rx_valid_o && rx_ready_i && !rst_i) rx_log.push_back(rx_data_o);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents one byte and returns the cycle in which it is accepted.
  task automatic applyStimulus(input logic [7:0] data, input logic last, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk_i);
    tx_data_i  = data;
    tx_last_i  = last;
    tx_valid_i = 1'b1;
    while (!tx_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("tx_accept_bound", 32'(n < 200), 1);
    acc_cyc = cyc;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    tx_last_i  = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("idle_bound", 32'(n < 500), 1);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    checkOutput("rst_ss_n", ss_n_o, 1);
    checkOutput("rst_start", spi_start_o, 0);
    checkOutput("rst_din", spi_din_o, 8'h00);
    checkOutput("rst_tx_ready", tx_ready_o, 1);
    checkOutput("rst_rx_valid", rx_valid_o, 0);
    checkOutput("rst_rx_data", rx_data_o, 8'h00);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_overrun", rx_overrun_o, 0);
    rst_i = 1'b0;

    // Single byte 0xAA, MISO 0x23.
    miso_key = 8'h89;
    rx_mode  = 0;
    bs = start_count;
    applyStimulus(8'hAA, 1'b1, t);
    waitIdle();
    repeat (2) @(negedge clk_i);
    checkOutput("t1_ss_fall", ss_fall_cyc, t + 1);
    checkOutput("t1_start_cyc", start_cyc, t + 1 + SS_SETUP);
    checkOutput("t1_start_count", start_count - bs, 1);
    checkOutput("t1_din", din_log[din_log.size() - 1], 8'hAA);
    checkOutput("t1_rx_valid_lat", rx_rise_cyc, done_cyc + 1);
    checkOutput("t1_rx_valid", rx_valid_o, 1);
    checkOutput("t1_rx_data", rx_data_o, 8'h23);
    checkOutput("t1_ss_rise", ss_rise_cyc, done_cyc + 1 + SS_HOLD);
    rx_mode = 1;
    repeat (3) @(negedge clk_i);
    checkOutput("t1_rx_drained", rx_valid_o, 0);

    // Three-byte burst with consumer always ready.
    miso_key = 8'h0F;
    bs = start_count; br = ss_rise_count; bf = ss_fall_count;
    bl = rx_log.size(); bd = din_log.size();
    applyStimulus(8'h00, 1'b0, t);
    applyStimulus(8'h55, 1'b0, t);
    applyStimulus(8'hFF, 1'b1, t);
    waitIdle();
    repeat (2) @(negedge clk_i);
    checkOutput("t2_start_count", start_count - bs, 3);
    checkOutput("t2_ss_fall_count", ss_fall_count - bf, 1);
    checkOutput("t2_ss_rise_count", ss_rise_count - br, 1);
    checkOutput("t2_din_1", din_log[bd + 1], 8'h55);
    checkOutput("t2_rx_count", rx_log.size() - bl, 3);
    checkOutput("t2_rx_0", rx_log[bl], 8'h0F);
    checkOutput("t2_rx_1", rx_log[bl + 1], 8'h5A);
    checkOutput("t2_rx_2", rx_log[bl + 2], 8'hF0);

    // Producer stalls 50 cycles between bytes.
    miso_key = 8'h00;
    bs = start_count; br = ss_rise_count;
    applyStimulus(8'h11, 1'b0, t);
    for (int n = 0; n < 100 && !tx_ready_o; n++) @(negedge clk_i);
    bd = start_count;
    repeat (50) @(negedge clk_i);
    checkOutput("t3_busy", busy_o, 1);
    checkOutput("t3_ss_low", ss_n_o, 0);
    checkOutput("t3_in_next", tx_ready_o, 1);
    checkOutput("t3_no_start", start_count - bd, 0);
    checkOutput("t3_no_ss_rise", ss_rise_count - br, 0);
    applyStimulus(8'h22, 1'b1, t2);
    waitIdle();
    checkOutput("t3_next_start", start_cyc, t2 + 1);
    checkOutput("t3_start_count", start_count - bs, 2);

    // Five bytes with consumer stalled: overrun once RX storage is exceeded.
    rx_mode = 0;
    bd = done_count; bl = rx_log.size();
    for (int i = 0; i < 5; i++) applyStimulus(8'hA0 + 8'(i), i == 4, t);
    waitIdle();
    checkOutput("t4_ovr_done_idx", ovr_rise_done - bd, FILL + 1);
    checkOutput("t4_overrun", rx_overrun_o, 1);
    rx_mode = 1;
    repeat (8) @(negedge clk_i);
    checkOutput("t4_rx_count", rx_log.size() - bl, FILL);
    for (int i = 0; i < FILL; i++) begin
`ifdef SPI_BURST_RX_FIFO_EN
      exp_b = 8'hA0 + 8'(i);
`else
      exp_b = 8'hA4;
`endif
      checkOutput("t4_rx_byte", rx_log[bl + i], exp_b);
    end
    checkOutput("t4_overrun_sticky", rx_overrun_o, 1);

    // Storage full, then pop coincides with a done tick.
    doReset();
    checkOutput("t5_overrun_clr", rx_overrun_o, 0);
    rx_mode    = 2;
    pop_target = done_count + FILL + 1;
    bl = rx_log.size();
    for (int i = 0; i <= FILL; i++) applyStimulus(8'hC0 + 8'(i), i == FILL, t);
    waitIdle();
    checkOutput("t5_no_overrun", rx_overrun_o, 0);
    checkOutput("t5_rx_valid", rx_valid_o, 1);
    checkOutput("t5_one_popped", rx_log.size() - bl, 1);
    rx_mode = 1;
    repeat (8) @(negedge clk_i);
    checkOutput("t5_rx_count", rx_log.size() - bl, FILL + 1);
    for (int i = 0; i <= FILL; i++) checkOutput("t5_rx_byte", rx_log[bl + i], 8'hC0 + 8'(i));

    // Reset during WAIT_DONE of the second byte, then a clean burst.
    rx_mode = 0;
    applyStimulus(8'h61, 1'b0, t);
    applyStimulus(8'h62, 1'b0, t);
    @(negedge clk_i);
    checkOutput("t6_pre_rx_valid", rx_valid_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t6_rst_ss_n", ss_n_o, 1);
    checkOutput("t6_rst_busy", busy_o, 0);
    checkOutput("t6_rst_rx_valid", rx_valid_o, 0);
    checkOutput("t6_rst_tx_ready", tx_ready_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    miso_key = 8'h66;
    rx_mode  = 1;
    bs = start_count; bl = rx_log.size();
    applyStimulus(8'h5A, 1'b1, t);
    waitIdle();
    repeat (3) @(negedge clk_i);
    checkOutput("t6_start_count", start_count - bs, 1);
    checkOutput("t6_rx_count", rx_log.size() - bl, 1);
    checkOutput("t6_rx_byte", rx_log[bl], 8'h3C);
    checkOutput("t6_ss_n_idle", ss_n_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
